// File: rtl/sequenciador_zonas.sv
// Staggered switch-on sequencer for N lighting zones: round-robin grants spaced
// at least STAGGER_T cycles apart, immediate switch-off and global force-off.
module sequenciador_zonas #(
  parameter int unsigned N_ZONAS   = 4,
  parameter int unsigned STAGGER_T = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ZONAS-1:0] pedido,
  input  logic               desliga_tudo,
  output logic [N_ZONAS-1:0] lampada,
  output logic               ocupado,
  output logic               pendente
);

  localparam int unsigned PTR_W = $clog2(N_ZONAS);
  localparam int unsigned CNT_W = (STAGGER_T > 1) ? $clog2(STAGGER_T) : 1;

  typedef enum logic {IDLE, ESPERA} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [N_ZONAS-1:0] r_lampada, w_lampada_nxt;
  logic [N_ZONAS-1:0] w_pend;
  logic [PTR_W-1:0]   w_k;
  logic               w_found;
  logic               w_grant_ok;
  int unsigned        w_idx;

  assign w_pend     = pedido & ~r_lampada;
  assign w_grant_ok = (r_state == IDLE) || (r_cnt == '0);

  // Rotating priority search: first pending zone at or after r_ptr, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_k     = '0;
    w_idx   = 0;
    for (int unsigned i = 0; i < N_ZONAS; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N_ZONAS) w_idx = w_idx - N_ZONAS;
      if (!w_found && w_pend[w_idx]) begin
        w_found = 1'b1;
        w_k     = PTR_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ptr_nxt     = r_ptr;
    w_lampada_nxt = r_lampada & pedido;
    if (desliga_tudo) begin
      w_lampada_nxt = '0;
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
    end else if (w_grant_ok) begin
      if (w_found) begin
        w_lampada_nxt[w_k] = 1'b1;
        w_ptr_nxt   = (w_k == PTR_W'(N_ZONAS - 1)) ? '0 : w_k + PTR_W'(1);
        w_cnt_nxt   = CNT_W'(STAGGER_T - 1);
        w_state_nxt = ESPERA;
      end else begin
        w_state_nxt = IDLE;
      end
    end else begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_lampada <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_lampada <= w_lampada_nxt;
    end
  end

  assign lampada  = r_lampada;
  assign ocupado  = (r_state == ESPERA) && (r_cnt != '0);
  assign pendente = !desliga_tudo && (|w_pend);

endmodule

// File: tb/tb_sequenciador_zonas.sv
// Scoreboard bench for sequenciador_zonas (N=4, S=10): an edges-since-last-grant
// reference model pushes expected outputs per edge; samples are popped after it.
module tb_sequenciador_zonas;

  localparam int unsigned N = 4;
  localparam int unsigned S = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] pedido = '0;
  logic         desliga_tudo = 1'b0;
  logic [N-1:0] lampada;
  logic         ocupado;
  logic         pendente;

  sequenciador_zonas #(.N_ZONAS(N), .STAGGER_T(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .pedido       (pedido),
    .desliga_tudo (desliga_tudo),
    .lampada      (lampada),
    .ocupado      (ocupado),
    .pendente     (pendente)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] lamp;
    logic         ocup;
  } exp_t;

  exp_t sb_q[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [N-1:0] m_lamp;
  int unsigned  m_ptr;
  int unsigned  m_age;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_lamp = '0;
    m_ptr  = 0;
    m_age  = S;
  endtask

  // Grants allowed once S-1 edges have passed since the previous grant.
  task automatic model_edge(input logic [N-1:0] ped, input logic dt);
    logic [N-1:0] pend;
    int unsigned  k;
    bit           hit;
    if (dt) begin
      m_lamp = '0;
      m_age  = S;
    end else begin
      pend   = ped & ~m_lamp;
      m_lamp = m_lamp & ped;
      hit    = 0;
      k      = 0;
      if (m_age >= S - 1) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (!hit && pend[(m_ptr + i) % N]) begin
            hit = 1;
            k   = (m_ptr + i) % N;
          end
        end
      end
      if (hit) begin
        m_lamp[k] = 1'b1;
        m_ptr     = (k + 1) % N;
        m_age     = 0;
      end else if (m_age < S) begin
        m_age++;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] ped, input logic dt);
    exp_t e;
    pedido       = ped;
    desliga_tudo = dt;
    #1;
    check("pendente", {31'b0, pendente}, {31'b0, !dt && (|(ped & ~m_lamp))});
    model_edge(ped, dt);
    e.lamp = m_lamp;
    e.ocup = (m_age < S - 1);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("lampada", {28'b0, lampada}, {28'b0, e.lamp});
      check("ocupado", {31'b0, ocupado}, {31'b0, e.ocup});
    end
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #2;
    check("rst_lampada", {28'b0, lampada}, 32'd0);
    check("rst_ocupado", {31'b0, ocupado}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int unsigned lit_at;

  initial begin
    // Test 1: reset held with all requests pending
    model_reset();
    rst = 1'b0;
    pedido = 4'b1111;
    repeat (5) @(posedge clk);
    #1;
    check("t1_lampada", {28'b0, lampada}, 32'd0);
    check("t1_ocupado", {31'b0, ocupado}, 32'd0);
    check("t1_pendente", {31'b0, pendente}, 32'd1);
    rst = 1'b1;
    step(4'b1111, 1'b0);
    check("t1_first", {28'b0, lampada}, 32'h1);

    // Test 2: stagger from idle
    async_reset();
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    for (int e = 0; e < 40; e++) begin
      step(4'b1111, 1'b0);
      if (e == 9)  check("t2_edge9", {28'b0, lampada}, 32'h1);
      if (e == 10) check("t2_edge10", {28'b0, lampada}, 32'h3);
      if (e == 30) check("t2_edge30", {28'b0, lampada}, 32'hF);
    end
    check("t2_idle_ocupado", {31'b0, ocupado}, 32'd0);
    check("t2_idle_pendente", {31'b0, pendente}, 32'd0);

    // Test 3: round-robin wrap with ptr=2
    async_reset();
    for (int e = 0; e < 11; e++) step(4'b0011, 1'b0);
    for (int e = 0; e < 12; e++) step(4'b0000, 1'b0);
    step(4'b0011, 1'b0);
    check("t3_zone0_first", {28'b0, lampada}, 32'h1);
    for (int e = 0; e < 10; e++) step(4'b0011, 1'b0);
    check("t3_zone1_next", {28'b0, lampada}, 32'h3);
    for (int e = 0; e < 12; e++) step(4'b0000, 1'b0);
    step(4'b1111, 1'b0);
    check("t3_ptr2", {28'b0, lampada}, 32'h4);

    // Test 4: immediate off during ESPERA and re-request
    for (int e = 0; e < 12; e++) step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    check("t4_zone0", {28'b0, lampada}, 32'h1);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    check("t4_off", {28'b0, lampada}, 32'h0);
    for (int e = 0; e < 3; e++) step(4'b0000, 1'b0);
    lit_at = 0;
    for (int e = 1; e <= 6; e++) begin
      step(4'b0001, 1'b0);
      if (lit_at == 0 && lampada[0]) lit_at = e;
    end
    check("t4_relit_step", lit_at, 32'd4);

    // Test 5: force-off mid-sequence
    for (int e = 0; e < 12; e++) step(4'b0000, 1'b0);
    for (int e = 0; e < 11; e++) step(4'b1111, 1'b0);
    check("t5_two_lit", {28'b0, lampada}, 32'h6);
    for (int e = 0; e < 3; e++) begin
      step(4'b1111, 1'b1);
      check("t5_forced_off", {28'b0, lampada}, 32'h0);
    end
    step(4'b1111, 1'b0);
    check("t5_release_grant", {28'b0, lampada}, 32'h8);

    // Test 6: async reset between edges during ESPERA
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    #2;
    async_reset();
    step(4'b1111, 1'b0);
    check("t6_restart", {28'b0, lampada}, 32'h1);
    for (int e = 0; e < 12; e++) step(4'b1111, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sequenciador_zonas.md
Name: sequenciador_zonas

Overview:
Sequences switch-on of N lighting zones, each requested by its own controladora instance through its saida output. Zones are switched on one at a time, at least STAGGER_T clock cycles apart, to limit inrush current. Simultaneous requests are served round-robin. Switch-off is immediate. A global force-off input clears every zone at once.

Parameters:
N_ZONAS, 4, number of zones (2..16).
STAGGER_T, 1000, minimum clock cycles between two successive switch-ons (1..2^24). A value of 1 allows a grant every cycle.

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-low.
pedido  input  N_ZONAS  per-zone level request (1 = zone wants light); synchronous and already debounced.
desliga_tudo  input  1  global force-off, level-sensitive.
lampada  output  N_ZONAS  registered zone drive (1 = lamp on).
ocupado  output  1  high while the stagger interval is running (state ESPERA with cnt != 0).
pendente  output  1  combinational OR of (pedido & ~lampada), forced to 0 while desliga_tudo = 1.

Behaviour:
- Reset: one clock and one reset. rst is asynchronous and active-low. While rst = 0: lampada = 0, state = IDLE, cnt = 0, ptr = 0, ocupado = 0. Operation resumes on the first clk edge after rst rises.
- Internal signals: pend = pedido & ~lampada; ptr = round-robin pointer, width clog2(N_ZONAS); cnt = down-counter, width clog2(STAGGER_T).
- Grant selection: first set bit of pend, searching ptr, ptr+1, ... N_ZONAS-1, 0, ... with wrap-around. The result is zone k.
- States: IDLE and ESPERA. A grant is "possible" in IDLE, and in ESPERA when cnt == 0.
- Grant possible and pend != 0:
  - lampada[k] <= 1.
  - ptr <= (k+1) mod N_ZONAS.
  - cnt <= STAGGER_T-1.
  - state <= ESPERA.
- Grant possible and pend == 0: state <= IDLE.
- ESPERA with cnt != 0: cnt <= cnt-1, no grant.
- Consequence: two grants occur exactly STAGGER_T edges apart when requests are continuously pending. Latency from pedido rising (idle block) to lampada rising is 1 edge.
- Switch-off:
  - Any zone with pedido[i] = 0 gets lampada[i] <= 0 on the next edge, in any state.
  - Switch-off does not touch cnt, state or ptr.
  - A zone that drops its request in the same cycle it would be selected is not granted, because pend uses the current pedido.
- Re-request: a zone that turns off and re-requests re-enters arbitration normally and must wait for the running stagger interval.
- Force-off: desliga_tudo = 1 at an edge gives lampada <= 0, state <= IDLE, cnt <= 0. ptr is held. No grants occur while it is high. After release, a grant is possible on the first edge it is sampled low.
- At most one lampada bit rises per edge.
- lampada bits are always a subset of pedido from the previous edge.
- Async reset mid-ESPERA clears all state immediately, without waiting for a clk edge.

Test Plan:
1. Reset: N=4, S=10. Hold rst=0 with pedido=4'b1111 for 5 clk → lampada=0, ocupado=0, pendente=1. Release rst → lampada=4'b0001 after the first edge.
2. Stagger: N=4, S=10, idle. pedido 0000→1111 before edge 0 → lampada bit0 at edge 0, bit1 at 10, bit2 at 20, bit3 at 30. ocupado=1 between grants. ocupado=0 and pendente=0 from edge 39.
3. Round-robin wrap: ptr=2 (last grant was zone 1), all lamps off, pedido=4'b0011 → zone0 granted first, zone1 granted 10 edges later, final ptr=2.
4. Immediate off during ESPERA: zone0 on, cnt=7. Drop pedido[0] → lampada[0]=0 next edge, cnt continues 6,5,…. Re-raise pedido[0] at cnt=3 → relit only when cnt reaches 0.
5. Force-off: 2 of 4 zones lit mid-sequence. Pulse desliga_tudo for 3 clk → lampada=0 and ocupado=0 on the first edge. No grant during the pulse. Zone at ptr granted on the first edge after release.
6. Async reset mid-operation: assert rst=0 between clk edges during ESPERA → lampada=0 and ocupado=0 immediately. After release, sequencing restarts from zone0.
